// File: rtl/mem_fifo_ctrl_pkg.sv
// mem_fifo_ctrl_pkg
//   Shared definitions for the mem FIFO controller: default word/address
//   widths and the controller FSM encoding.
package mem_fifo_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAULT  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/mem_fifo_ctrl_fifo_ptr.sv
// fifo_ptr
//   Write/read pointers and occupancy count for the circular FIFO, plus the
//   occupancy flags derived from the registered count.
// Ports
//   clk, rst_n              clock, async active-low reset
//   push_acc, pop_acc       accept strobes (never both high in one cycle)
//   wr_ptr, rd_ptr          current mem addresses for the next write/read
//   full, empty             count == DEPTH / count == 0
//   almost_full             count >= DEPTH - AF_MARGIN
//   almost_empty            count <= AE_MARGIN
module fifo_ptr
  import mem_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_acc,
  input  logic                  pop_acc,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_MARGIN);

  logic [CW-1:0] count;

  // Pointers wrap by natural overflow of ADDR_WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

endmodule

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl
//   Turns the mem block into an 8-entry circular FIFO. Arbitrates producer
//   pushes and consumer pops (one mem op per cycle, round-robin when both are
//   legal), drives registered mem write/read strobes, passes returning read
//   data straight through as pop_data/pop_valid, and latches a sticky fault
//   when the mem reports an error or breaks the one-cycle read protocol.
// Ports
//   clk, RESET_L                          clock, async active-low reset
//   push, push_data, push_ready           producer side
//   pop, pop_ready, pop_data, pop_valid   consumer side
//   address, data, write, read            to mem
//   data_out, valid_out, err              from mem
//   full, empty, almost_full, almost_empty  occupancy flags
//   fifo_err                              sticky fault flag
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_INIT   | one settling cycle after reset, no requests accepted
// ST_ACTIVE | normal operation, faults checked every cycle
// ST_FAULT  | sticky fault, no requests accepted, no mem ops; exit by reset
module mem_fifo_ctrl
  import mem_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop,
  output logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  write,
  output logic                  read,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  valid_out,
  input  logic                  err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_err
);

  fifo_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic active, fault_now, can_go;
  logic push_legal, pop_legal, push_acc, pop_acc;
  logic rr_pop;       // 1: pop wins the next contended cycle
  logic rd_pending;   // read was issued last cycle, data due now

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_MARGIN  (AF_MARGIN),
    .AE_MARGIN  (AE_MARGIN)
  ) u_ptr (
    .clk          (clk),
    .rst_n        (RESET_L),
    .push_acc     (push_acc),
    .pop_acc      (pop_acc),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  assign active = (state == ST_ACTIVE);

  // A mem that answers without a request, or stays silent after one, is as
  // bad as an explicit err.
  assign fault_now = active & (err | (valid_out ^ rd_pending));

  // Nothing is accepted on the faulting cycle so no op is issued in FAULT.
  assign can_go = active & ~fault_now;

  assign push_legal = push & ~full;
  assign pop_legal  = pop & ~empty;

  assign push_ready = can_go & ~full  & ~(pop_legal & rr_pop);
  assign pop_ready  = can_go & ~empty & ~(push_legal & ~rr_pop);

  assign push_acc = push & push_ready;
  assign pop_acc  = pop & pop_ready;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) state <= ST_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (fault_now) state_nxt = ST_FAULT;
      ST_FAULT:  state_nxt = ST_FAULT;
      default:   state_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      rr_pop     <= 1'b0;
      write      <= 1'b0;
      read       <= 1'b0;
      address    <= '0;
      data       <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (can_go && push_legal && pop_legal) rr_pop <= ~rr_pop;
      write      <= push_acc;
      read       <= pop_acc;
      rd_pending <= read;
      if (push_acc) begin
        address <= wr_ptr;
        data    <= push_data;
      end else if (pop_acc) begin
        address <= rd_ptr;
      end
    end
  end

  // Read data is passed through in the cycle mem presents it; a read that
  // coincides with err is the faulting one and is not delivered.
  assign pop_valid = active & valid_out & rd_pending & ~err;
  assign pop_data  = pop_valid ? data_out : '0;

  assign fifo_err = (state == ST_FAULT);

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
module tb_mem_fifo_ctrl;

  logic       clk = 1'b0;
  logic       RESET_L;
  logic       push, pop;
  logic [5:0] push_data;
  logic       push_ready, pop_ready, pop_valid;
  logic [5:0] pop_data;
  logic [2:0] address;
  logic [5:0] data;
  logic       write, read;
  logic [5:0] data_out;
  logic       valid_out, err;
  logic       full, empty, almost_full, almost_empty, fifo_err;

  mem_fifo_ctrl dut (
    .clk          (clk),
    .RESET_L      (RESET_L),
    .push         (push),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .pop          (pop),
    .pop_ready    (pop_ready),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .address      (address),
    .data         (data),
    .write        (write),
    .read         (read),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .err          (err),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_err     (fifo_err)
  );

  always #5 clk = ~clk;

  // Behavioural mem: one-cycle read latency, not reset with the controller.
  logic [5:0] mem_arr [8];
  logic       mem_vld  = 1'b0;
  logic [5:0] mem_dout = 6'd0;
  logic       spur_vld;

  always @(posedge clk) begin
    if (write) mem_arr[address] <= data;
    mem_vld  <= read;
    mem_dout <= mem_arr[address];
  end
  assign valid_out = mem_vld | spur_vld;
  assign data_out  = mem_dout;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct { int due; logic [2:0] a; logic [5:0] d; } op_t;
  op_t        wr_q [$];
  op_t        rd_q [$];
  op_t        pv_q [$];
  logic [5:0] model_q [$];
  logic [2:0] m_wr = 3'd0;
  logic [2:0] m_rd = 3'd0;

  // Monitor / scoreboard: expectations are queued on observed accepts and
  // retired when the DUT presents write, read or pop_valid.
  always @(negedge clk) begin
    if (!RESET_L) begin
      wr_q.delete(); rd_q.delete(); pv_q.delete(); model_q.delete();
      m_wr <= 3'd0;
      m_rd <= 3'd0;
    end else begin
      if (push && push_ready) begin
        chk(!full, "push_ready_while_full", int'(full), 0);
        wr_q.push_back('{cyc + 1, m_wr, push_data});
        model_q.push_back(push_data);
        m_wr <= m_wr + 3'd1;
      end
      if (pop && pop_ready) begin
        chk(model_q.size() != 0, "pop_ready_while_empty", model_q.size(), 1);
        if (model_q.size() != 0) begin
          rd_q.push_back('{cyc + 1, m_rd, 6'd0});
          pv_q.push_back('{cyc + 2, 3'd0, model_q.pop_front()});
        end
        m_rd <= m_rd + 3'd1;
      end
      if (write || read) chk(!(write && read), "write_and_read", int'({write, read}), 1);
      if (write) begin
        if (wr_q.size() == 0) chk(1'b0, "unexpected_write", int'(address), 0);
        else begin
          chk(wr_q[0].due == cyc && address == wr_q[0].a && data == wr_q[0].d,
              "write_addr_data", int'({address, data}), int'({wr_q[0].a, wr_q[0].d}));
          void'(wr_q.pop_front());
        end
      end else if (wr_q.size() != 0 && wr_q[0].due <= cyc) begin
        chk(1'b0, "missing_write", 0, 1);
        void'(wr_q.pop_front());
      end
      if (read) begin
        if (rd_q.size() == 0) chk(1'b0, "unexpected_read", int'(address), 0);
        else begin
          chk(rd_q[0].due == cyc && address == rd_q[0].a, "read_addr",
              int'(address), int'(rd_q[0].a));
          void'(rd_q.pop_front());
        end
      end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        chk(1'b0, "missing_read", 0, 1);
        void'(rd_q.pop_front());
      end
      if (pop_valid) begin
        if (pv_q.size() == 0) chk(1'b0, "unexpected_pop_valid", int'(pop_data), 0);
        else begin
          chk(pv_q[0].due == cyc && pop_data == pv_q[0].d, "pop_data",
              int'(pop_data), int'(pv_q[0].d));
          void'(pv_q.pop_front());
        end
      end else if (pv_q.size() != 0 && pv_q[0].due <= cyc) begin
        chk(1'b0, "missing_pop_valid", 0, int'(pv_q[0].d));
        void'(pv_q.pop_front());
      end
    end
  end

  task automatic push_word(input logic [5:0] d);
    int n = 0;
    push = 1'b1; push_data = d;
    @(negedge clk);
    while (!push_ready && n < 20) begin @(negedge clk); n++; end
    if (!push_ready) chk(1'b0, "push_timeout", 0, 1);
    @(posedge clk); #1;
    push = 1'b0;
  endtask

  task automatic pop_word();
    int n = 0;
    pop = 1'b1;
    @(negedge clk);
    while (!pop_ready && n < 20) begin @(negedge clk); n++; end
    if (!pop_ready) chk(1'b0, "pop_timeout", 0, 1);
    @(posedge clk); #1;
    pop = 1'b0;
  endtask

  task automatic reset_dut();
    RESET_L = 1'b0; push = 1'b0; pop = 1'b0; err = 1'b0; spur_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 RESET_L = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] rv;
    RESET_L = 1'b0; push = 1'b0; pop = 1'b0; push_data = 6'd0;
    err = 1'b0; spur_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rv = {empty, almost_empty, full, almost_full, push_ready, pop_ready,
          write, read, pop_valid, fifo_err};
    chk(rv == 10'b1100000000, "reset_outputs", int'(rv), 'h300);
    chk(address == 3'd0 && data == 6'd0, "reset_addr_data", int'({address, data}), 0);

    // INIT cycle accepts nothing
    RESET_L = 1'b1;
    push = 1'b1; push_data = 6'h01;
    @(negedge clk);
    chk(push_ready == 1'b0, "init_push_ready", int'(push_ready), 0);
    @(posedge clk); #1;

    // Fill 0x01..0x08 back-to-back
    for (int i = 0; i < 8; i++) begin
      push_word(6'(i + 1));
      rv = {6'd0, full, empty, almost_full, almost_empty};
      chk(rv[3:0] == {(i == 7), 1'b0, (i + 1 >= 6), (i + 1 <= 2)}, "fill_flags",
          int'(rv[3:0]), int'({(i == 7), 1'b0, (i + 1 >= 6), (i + 1 <= 2)}));
    end
    push = 1'b1; push_data = 6'h09;
    @(negedge clk);
    chk(push_ready == 1'b0, "ninth_push_ready", int'(push_ready), 0);
    @(posedge clk); #1;
    push = 1'b0;

    // Drain 8
    for (int i = 0; i < 8; i++) pop_word();
    repeat (3) @(posedge clk);
    #1;
    chk(empty == 1'b1 && almost_empty == 1'b1, "drain_empty", int'({empty, almost_empty}), 3);
    chk(pv_q.size() == 0, "drain_all_delivered", pv_q.size(), 0);

    // Contention at count 4: push wins first, then alternates
    for (int i = 0; i < 4; i++) push_word(6'(8'h11 + i));
    push = 1'b1; pop = 1'b1; push_data = 6'h21;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk(push_ready == (k % 2 == 0) && pop_ready == (k % 2 == 1), "contend_ready",
          int'({push_ready, pop_ready}), (k % 2 == 0) ? 2 : 1);
      chk(!full && !empty, "contend_count_range", int'({full, empty}), 0);
      @(posedge clk); #1;
      if (k % 2 == 0) push_data = push_data + 6'd1;
    end
    push = 1'b0; pop = 1'b0;
    for (int i = 0; i < 3; i++) pop_word();
    chk(empty == 1'b0, "contend_three_left", int'(empty), 0);
    pop_word();
    chk(empty == 1'b1, "contend_count_was_4", int'(empty), 1);
    repeat (3) @(posedge clk);
    #1;
    chk(pv_q.size() == 0, "contend_all_delivered", pv_q.size(), 0);

    // Wrap: fill 8, pop 3, push 3 at addresses 0..2, drain in order
    reset_dut();
    for (int i = 0; i < 8; i++) push_word(6'(8'h31 + i));
    for (int i = 0; i < 3; i++) pop_word();
    for (int i = 0; i < 3; i++) begin
      push_word(6'(8'h39 + i));
      chk(write == 1'b1 && address == 3'(i), "wrap_write_addr", int'(address), i);
    end
    chk(full == 1'b1, "wrap_full", int'(full), 1);
    for (int i = 0; i < 8; i++) pop_word();
    repeat (3) @(posedge clk);
    #1;
    chk(empty == 1'b1 && pv_q.size() == 0, "wrap_drained", pv_q.size(), 0);

    // Mem err -> sticky fault
    reset_dut();
    push_word(6'h05);
    push_word(6'h06);
    err = 1'b1; push = 1'b1; pop = 1'b1; push_data = 6'h07;
    @(posedge clk); #1;
    err = 1'b0;
    chk(fifo_err == 1'b1, "err_fifo_err", int'(fifo_err), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({fifo_err, push_ready, pop_ready, write, read} == 5'b10000, "fault_hold",
          int'({fifo_err, push_ready, pop_ready, write, read}), 'h10);
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;

    // Spurious valid_out with no read outstanding
    reset_dut();
    spur_vld = 1'b1;
    @(negedge clk);
    chk(pop_valid == 1'b0, "spurious_no_pop_valid", int'(pop_valid), 0);
    @(posedge clk); #1;
    spur_vld = 1'b0;
    chk(fifo_err == 1'b1, "spurious_fault", int'(fifo_err), 1);

    // Reset during an in-flight read
    reset_dut();
    push_word(6'h2A);
    push_word(6'h2B);
    pop_word();
    chk(read == 1'b1, "inflight_read_issued", int'(read), 1);
    RESET_L = 1'b0;
    #1;
    chk({read, empty, pop_valid} == 3'b010, "async_reset_outputs",
        int'({read, empty, pop_valid}), 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(pop_valid == 1'b0, "reset_pop_valid", int'(pop_valid), 0);
    end
    @(posedge clk); #1;
    RESET_L = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(pop_valid == 1'b0 && empty == 1'b1, "post_reset_quiet",
          int'({pop_valid, empty}), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
